mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, number of WAIT cycles per memory access; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ifu_req_valid  input  1  instruction-fetch read request.
REQ-005 ifu_req_ready  output  1  IFU request accepted this cycle when high with valid.
REQ-006 ifu_addr  input  64  IFU read address.
REQ-007 ifu_resp_valid  output  1  one-cycle IFU read-data strobe.
REQ-008 ifu_rdata  output  64  IFU read data.
REQ-009 lsu_req_valid / lsu_req_ready  input / output  1 / 1  LSU request handshake.
REQ-010 lsu_wen  input  1  LSU request is a write (1) or read (0).
REQ-011 lsu_addr, lsu_wdata  input  64 each  LSU address, write data.
REQ-012 lsu_wmask  input  8  LSU byte write mask.
REQ-013 lsu_resp_valid / lsu_rdata  output  1 / 64  one-cycle LSU completion strobe; read data (zero for writes).
REQ-014 mem_raddr, mem_waddr, mem_wdata  output  64 each  shared memory port address/data.
REQ-015 mem_wmask / mem_wen  output  8 / 1  shared memory port byte mask; write enable.
REQ-016 mem_rdata  input  64  shared memory port read data (combinational from mem_raddr).

Function
REQ-017 FSM states: IDLE, WAIT, RESP; one outstanding access total.
REQ-018 In IDLE, ready SHALL be high only toward the requester the arbiter selects that cycle; both ready low in WAIT and RESP.
REQ-019 Acceptance (valid && ready in IDLE) SHALL latch owner, address, wen, wdata, wmask, load counter with LATENCY, and move to WAIT.
REQ-020 In WAIT, mem_raddr/mem_waddr SHALL present the latched address; mem_wdata/mem_wmask present latched values; all four zero in IDLE and RESP.
REQ-021 mem_wen SHALL be high for exactly the first WAIT cycle of a write, never otherwise (one write per request).
REQ-022 Counter decrements each WAIT cycle; in the cycle counter==1, mem_rdata SHALL be registered (zeroed for writes) and FSM moves to RESP.
REQ-023 In RESP, the owner's resp_valid SHALL be high for exactly one cycle with rdata valid; FSM returns to IDLE; no response backpressure.
REQ-024 Latency: accept at edge T -> resp_valid in cycle T+LATENCY+1; next acceptance earliest in the cycle after RESP.
REQ-025 rdata outputs SHALL hold last response value between strobes; non-owner resp_valid stays low.
REQ-026 Requests deasserted while not accepted SHALL be dropped without side effect; requester inputs ignored outside IDLE.

Reset
REQ-027 rst_n low at an edge SHALL force IDLE, counter 0, all resp_valid, ready, mem_wen low, all data/address outputs 0, RR pointer to "IFU last".
REQ-028 Reset mid-WAIT/RESP SHALL abandon the access with no response and no further mem_wen.

Configuration
REQ-029 Macro MEM_ARB_RR_EN undefined: fixed priority, LSU wins simultaneous requests.
REQ-030 MEM_ARB_RR_EN defined: round-robin; simultaneous requests grant the requester not granted last; single requester always granted; pointer updates on acceptance only.

Verification
REQ-031 LATENCY=1, IFU read addr 0x8000_0000, mem_rdata 0x1234 -> ifu_resp_valid exactly 2 cycles after accept, ifu_rdata 0x1234.
REQ-032 LSU write addr 0x8000_0010, wdata 0xAA, wmask 0x0F -> mem_wen high one cycle with those values, lsu_resp_valid one cycle later, lsu_rdata 0.
REQ-033 Both valid continuously, 4 transactions, fixed priority -> all LSU; with MEM_ARB_RR_EN -> LSU, IFU, LSU, IFU.
REQ-034 LATENCY=3, LSU read -> address held 3 WAIT cycles, resp 4 cycles after accept, ready low until after RESP.
REQ-035 rst_n low during WAIT of a write -> no resp_valid, no second mem_wen, outputs 0, next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) arbiter onto a single shared memory port, one access in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.

module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen,
    input  logic [63:0] mem_rdata
);

    // state | meaning
    // IDLE  | accepting the selected requester
    // WAIT  | memory port driven, counting LATENCY cycles
    // RESP  | one-cycle response strobe to the owner
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_lsu;
    logic       wen_q;
    logic       grant_lsu;
    logic       grant_ifu;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    // Pointer only moves on a real acceptance, never on a dropped request.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_lsu <= 1'b0;
        else if (lsu_req_ready)
            last_lsu <= 1'b1;
        else if (ifu_req_ready)
            last_lsu <= 1'b0;
    end

    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
`else
    assign grant_lsu = lsu_req_valid;
`endif

    assign grant_ifu     = ifu_req_valid && !grant_lsu;
    assign lsu_req_ready = rst_n && (state == IDLE) && grant_lsu;
    assign ifu_req_ready = rst_n && (state == IDLE) && grant_ifu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            owner_lsu      <= 1'b0;
            wen_q          <= 1'b0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= 64'd0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= 64'd0;
            mem_raddr      <= 64'd0;
            mem_waddr      <= 64'd0;
            mem_wdata      <= 64'd0;
            mem_wmask      <= 8'd0;
            mem_wen        <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            mem_wen        <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_req_ready || ifu_req_ready) begin
                        state     <= WAIT;
                        cnt       <= 4'(LATENCY);
                        owner_lsu <= lsu_req_ready;
                        if (lsu_req_ready) begin
                            mem_raddr <= lsu_addr;
                            mem_waddr <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                            mem_wen   <= lsu_wen;
                            wen_q     <= lsu_wen;
                        end else begin
                            mem_raddr <= ifu_addr;
                            mem_waddr <= ifu_addr;
                            mem_wdata <= 64'd0;
                            mem_wmask <= 8'd0;
                            wen_q     <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        cnt       <= 4'd0;
                        mem_raddr <= 64'd0;
                        mem_waddr <= 64'd0;
                        mem_wdata <= 64'd0;
                        mem_wmask <= 8'd0;
                        if (owner_lsu) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= wen_q ? 64'd0 : mem_rdata;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=1 and LATENCY=3 instances share stimulus,
// with request valids steered to one instance at a time.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel3 = 1'b0;
    logic        ifu_v = 1'b0, lsu_v = 1'b0, lsu_we = 1'b0;
    logic [63:0] ifu_a = '0, lsu_a = '0, lsu_wd = '0;
    logic [7:0]  lsu_wm = '0;

    logic        d1_ifu_rdy, d1_ifu_rv, d1_lsu_rdy, d1_lsu_rv, d1_mwen;
    logic [63:0] d1_ifu_rd, d1_lsu_rd, d1_mra, d1_mwa, d1_mwd, d1_mrd;
    logic [7:0]  d1_mwm;
    logic        d3_ifu_rdy, d3_ifu_rv, d3_lsu_rdy, d3_lsu_rv, d3_mwen;
    logic [63:0] d3_ifu_rd, d3_lsu_rd, d3_mra, d3_mwa, d3_mwd, d3_mrd;
    logic [7:0]  d3_mwm;

    int total = 0;
    int passed = 0;
    logic [63:0] last_ifu_rd = '0;
    logic [63:0] last_lsu_rd = '0;

    always #5 clk = ~clk;

    function automatic logic [63:0] memf(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h1234 : (a ^ 64'hDEAD_BEEF_0000_0000);
    endfunction

    assign d1_mrd = memf(d1_mra);
    assign d3_mrd = memf(d3_mra);

    mem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_v && !sel3), .ifu_req_ready(d1_ifu_rdy), .ifu_addr(ifu_a),
        .ifu_resp_valid(d1_ifu_rv), .ifu_rdata(d1_ifu_rd),
        .lsu_req_valid(lsu_v && !sel3), .lsu_req_ready(d1_lsu_rdy), .lsu_wen(lsu_we),
        .lsu_addr(lsu_a), .lsu_wdata(lsu_wd), .lsu_wmask(lsu_wm),
        .lsu_resp_valid(d1_lsu_rv), .lsu_rdata(d1_lsu_rd),
        .mem_raddr(d1_mra), .mem_waddr(d1_mwa), .mem_wdata(d1_mwd), .mem_wmask(d1_mwm),
        .mem_wen(d1_mwen), .mem_rdata(d1_mrd));

    mem_arbiter #(.LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_v && sel3), .ifu_req_ready(d3_ifu_rdy), .ifu_addr(ifu_a),
        .ifu_resp_valid(d3_ifu_rv), .ifu_rdata(d3_ifu_rd),
        .lsu_req_valid(lsu_v && sel3), .lsu_req_ready(d3_lsu_rdy), .lsu_wen(lsu_we),
        .lsu_addr(lsu_a), .lsu_wdata(lsu_wd), .lsu_wmask(lsu_wm),
        .lsu_resp_valid(d3_lsu_rv), .lsu_rdata(d3_lsu_rd),
        .mem_raddr(d3_mra), .mem_waddr(d3_mwa), .mem_wdata(d3_mwd), .mem_wmask(d3_mwm),
        .mem_wen(d3_mwen), .mem_rdata(d3_mrd));

    logic        v_ifu_rdy, v_lsu_rdy, v_ifu_rv, v_lsu_rv, v_mwen;
    logic [63:0] v_ifu_rd, v_lsu_rd, v_mra, v_mwa, v_mwd;
    logic [7:0]  v_mwm;
    assign v_ifu_rdy = sel3 ? d3_ifu_rdy : d1_ifu_rdy;
    assign v_lsu_rdy = sel3 ? d3_lsu_rdy : d1_lsu_rdy;
    assign v_ifu_rv  = sel3 ? d3_ifu_rv  : d1_ifu_rv;
    assign v_lsu_rv  = sel3 ? d3_lsu_rv  : d1_lsu_rv;
    assign v_mwen    = sel3 ? d3_mwen    : d1_mwen;
    assign v_ifu_rd  = sel3 ? d3_ifu_rd  : d1_ifu_rd;
    assign v_lsu_rd  = sel3 ? d3_lsu_rd  : d1_lsu_rd;
    assign v_mra     = sel3 ? d3_mra     : d1_mra;
    assign v_mwa     = sel3 ? d3_mwa     : d1_mwa;
    assign v_mwd     = sel3 ? d3_mwd     : d1_mwd;
    assign v_mwm     = sel3 ? d3_mwm     : d1_mwm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifu_v = 1'b0; lsu_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_ifu_rd = '0;
        last_lsu_rd = '0;
    endtask

    // Called at a negedge with the selected DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_txn(input logic iv, input logic lv, input logic hold, input logic exp_lsu,
                           input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input int lat);
        logic [63:0] exp_rd, exp_wd;
        logic [7:0]  exp_wm;
        ifu_v = iv; lsu_v = lv;
        ifu_a = addr; lsu_a = addr; lsu_we = wen; lsu_wd = wdata; lsu_wm = wmask;
        exp_wd = exp_lsu ? wdata : 64'd0;
        exp_wm = exp_lsu ? wmask : 8'd0;
        exp_rd = (exp_lsu && wen) ? 64'd0 : memf(addr);
        #1;
        check("grant", {62'd0, v_ifu_rdy, v_lsu_rdy}, exp_lsu ? 64'd1 : 64'd2);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin ifu_v = 1'b0; lsu_v = 1'b0; end
        for (int k = 0; k < lat; k++) begin
            check("wait_raddr", v_mra, addr);
            check("wait_waddr", v_mwa, addr);
            check("wait_wdata", v_mwd, exp_wd);
            check("wait_wmask", {56'd0, v_mwm}, {56'd0, exp_wm});
            check("wait_wen", {63'd0, v_mwen}, {63'd0, (k == 0) && exp_lsu && wen});
            check("wait_ready", {62'd0, v_ifu_rdy, v_lsu_rdy}, 64'd0);
            check("wait_resp", {62'd0, v_ifu_rv, v_lsu_rv}, 64'd0);
            @(negedge clk);
        end
        if (exp_lsu) last_lsu_rd = exp_rd; else last_ifu_rd = exp_rd;
        check("resp_valid", {62'd0, v_ifu_rv, v_lsu_rv}, exp_lsu ? 64'd1 : 64'd2);
        check("resp_ifu_rdata", v_ifu_rd, last_ifu_rd);
        check("resp_lsu_rdata", v_lsu_rd, last_lsu_rd);
        check("resp_mem_idle", v_mra | v_mwa | v_mwd | {55'd0, v_mwen, v_mwm}, 64'd0);
        check("resp_ready", {62'd0, v_ifu_rdy, v_lsu_rdy}, 64'd0);
        @(negedge clk);
        check("idle_resp_low", {62'd0, v_ifu_rv, v_lsu_rv}, 64'd0);
        check("idle_rdata_hold", v_ifu_rd ^ v_lsu_rd, last_ifu_rd ^ last_lsu_rd);
    endtask

    typedef struct {
        logic iv;
        logic lv;
        logic exp_ir;
        logic exp_lr;
    } vec_t;

    vec_t vecs[4];
    logic exp_owner;
    int   bad;

    initial begin
        vecs[0] = '{iv: 1'b0, lv: 1'b0, exp_ir: 1'b0, exp_lr: 1'b0};
        vecs[1] = '{iv: 1'b1, lv: 1'b0, exp_ir: 1'b1, exp_lr: 1'b0};
        vecs[2] = '{iv: 1'b0, lv: 1'b1, exp_ir: 1'b0, exp_lr: 1'b1};
        vecs[3] = '{iv: 1'b1, lv: 1'b1, exp_ir: 1'b0, exp_lr: 1'b1};

        // Reset state, with requests pending during reset
        ifu_v = 1'b1; lsu_v = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {62'd0, v_ifu_rdy, v_lsu_rdy}, 64'd0);
        check("rst_outputs", v_ifu_rd | v_lsu_rd | v_mra | v_mwa | v_mwd |
              {54'd0, v_ifu_rv, v_lsu_rv, v_mwen, v_mwm}, 64'd0);
        ifu_v = 1'b0; lsu_v = 1'b0;
        rst_n = 1'b1;

        // Combinational grant table; valids drop before the edge so nothing is accepted
        for (int i = 0; i < 4; i++) begin
            ifu_v = vecs[i].iv; lsu_v = vecs[i].lv;
            #1;
            check($sformatf("vec%0d_ready", i), {62'd0, v_ifu_rdy, v_lsu_rdy},
                  {62'd0, vecs[i].exp_ir, vecs[i].exp_lr});
            ifu_v = 1'b0; lsu_v = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        check("dropped_no_effect", v_mra | {62'd0, v_mwen, v_lsu_rv}, 64'd0);

        // IFU read, then LSU write
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'd0, 1);
        check("ifu_rdata_1234", v_ifu_rd, 64'h1234);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0010, 64'hAA, 8'h0F, 1);
        check("lsu_write_rdata", v_lsu_rd, 64'd0);

        // Both requesters continuously valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_owner = (i % 2 == 0);
`else
            exp_owner = 1'b1;
`endif
            run_txn(1'b1, 1'b1, 1'b1, exp_owner, 1'b0, 64'h100 + 64'(i * 8), 64'd0, 8'd0, 1);
        end
        ifu_v = 1'b0; lsu_v = 1'b0;

        // LATENCY=3 LSU read with valid held through the access
        sel3 = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h8000_0040, 64'd0, 8'd0, 3);
        lsu_v = 1'b0;
        @(negedge clk);

        // Reset in the middle of a LATENCY=3 write
        lsu_v = 1'b1; lsu_we = 1'b1; lsu_a = 64'h8000_0080; lsu_wd = 64'h55; lsu_wm = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        lsu_v = 1'b0;
        check("mid_wen_first", {63'd0, v_mwen}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_outputs", v_mra | v_mwa | v_mwd | v_lsu_rd |
              {55'd0, v_mwen, v_mwm}, 64'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (v_mwen || v_lsu_rv || v_ifu_rv) bad++;
            @(negedge clk);
        end
        check("mid_rst_quiet", 64'(bad), 64'd0);
        last_ifu_rd = '0;
        last_lsu_rd = '0;
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_00C0, 64'd0, 8'd0, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
